// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : serialises icache refills and LSB loads/stores onto the
//               byte-wide RAM/IO port. Optional: MEM_ARB_ROUND_ROBIN_EN
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int          FETCH_BYTES  = 4,
  parameter logic [31:0] IO_ADDR_BASE = 32'h30000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic        icache_req,
  input  logic [31:0] icache_addr,
  output logic        icache_ready,
  output logic [31:0] icache_data,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [1:0]  lsb_size,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_ready,
  output logic [31:0] lsb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IFETCH = 3'd1,
    S_LREAD  = 3'd2,
    S_SWRITE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  dout_q, dout_d;
  logic        wr_q, wr_d;
  logic        iready_q, iready_d;
  logic        lready_q, lready_d;
  logic        is_wr_q, is_wr_d;

  logic [2:0]  w_size_len, w_rd_len, w_beat_idx;
  logic [31:0] w_rd_base, w_wr_addr;
  logic [7:0]  w_wr_byte;
  logic        w_wr_stall, w_lsb_first, w_grant_lsb;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_lsb_q, last_lsb_d;
  assign w_lsb_first = ~last_lsb_q;
`else
  assign w_lsb_first = 1'b1;
`endif

  assign w_grant_lsb = lsb_req & (~icache_req | w_lsb_first);
  assign w_size_len  = (lsb_size == 2'b00) ? 3'd1 : (lsb_size == 2'b01) ? 3'd2 : 3'd4;
  assign w_rd_len    = (state_q == S_IFETCH) ? 3'(FETCH_BYTES) : w_size_len;
  assign w_rd_base   = (state_q == S_IFETCH) ? icache_addr : lsb_addr;
  // Beat 0 of a store is issued from IDLE on the accept edge itself.
  assign w_beat_idx  = (state_q == S_IDLE) ? 3'd0 : cnt_q;
  assign w_wr_addr   = lsb_addr + {29'd0, w_beat_idx};
  assign w_wr_byte   = lsb_wdata[{w_beat_idx[1:0], 3'b000} +: 8];
  assign w_wr_stall  = (w_wr_addr >= IO_ADDR_BASE) && io_buffer_full;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem_a_d  = mem_a_q;
    data_d   = data_q;
    dout_d   = 8'h00;
    wr_d     = 1'b0;
    iready_d = 1'b0;
    lready_d = 1'b0;
    is_wr_d  = is_wr_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_lsb_d = last_lsb_q;
`endif
    case (state_q)
      S_IDLE: begin
        mem_a_d = 32'h0;
        cnt_d   = 3'd0;
        if (w_grant_lsb) begin
          data_d  = 32'h0;
          is_wr_d = lsb_wr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_lsb_d = 1'b1;
`endif
          if (lsb_wr) begin
            state_d = S_SWRITE;
            mem_a_d = w_wr_addr;
            if (!w_wr_stall) begin
              dout_d = w_wr_byte;
              wr_d   = 1'b1;
              cnt_d  = 3'd1;
            end
          end else begin
            state_d = S_LREAD;
            mem_a_d = lsb_addr;
          end
        end else if (icache_req) begin
          state_d = S_IFETCH;
          mem_a_d = icache_addr;
          data_d  = 32'h0;
          is_wr_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_lsb_d = 1'b0;
`endif
        end
      end
      S_IFETCH, S_LREAD: begin
        if (rob_clear) begin
          state_d = S_IDLE;
          mem_a_d = 32'h0;
          cnt_d   = 3'd0;
        end else if (cnt_q < w_rd_len) begin
          data_d[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
          cnt_d = cnt_q + 3'd1;
          if ((cnt_q + 3'd1) < w_rd_len)
            mem_a_d = w_rd_base + {29'd0, cnt_q + 3'd1};
        end else begin
          state_d  = S_DONE;
          mem_a_d  = 32'h0;
          cnt_d    = 3'd0;
          iready_d = (state_q == S_IFETCH);
          lready_d = (state_q == S_LREAD);
        end
      end
      S_SWRITE: begin
        if (cnt_q >= w_size_len) begin
          state_d  = S_DONE;
          mem_a_d  = 32'h0;
          cnt_d    = 3'd0;
          lready_d = 1'b1;
        end else if (!w_wr_stall) begin
          mem_a_d = w_wr_addr;
          dout_d  = w_wr_byte;
          wr_d    = 1'b1;
          cnt_d   = cnt_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        mem_a_d = 32'h0;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      mem_a_q  <= 32'h0;
      data_q   <= 32'h0;
      dout_q   <= 8'h00;
      wr_q     <= 1'b0;
      iready_q <= 1'b0;
      lready_q <= 1'b0;
      is_wr_q  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_lsb_q <= 1'b1;
`endif
    end else if (rdy) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_a_q  <= mem_a_d;
      data_q   <= data_d;
      dout_q   <= dout_d;
      wr_q     <= wr_d;
      iready_q <= iready_d;
      lready_q <= lready_d;
      is_wr_q  <= is_wr_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_lsb_q <= last_lsb_d;
`endif
    end
  end

  // A flush landing on a read's DONE cycle suppresses the pulse; stores still report.
  assign icache_ready = iready_q & ~rob_clear;
  assign lsb_ready    = lready_q & ~(rob_clear & ~is_wr_q);
  assign icache_data  = data_q;
  assign lsb_rdata    = data_q;
  assign mem_a        = mem_a_q;
  assign mem_wr       = wr_q;
  assign mem_dout     = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, rob_clear;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ready;
  logic [31:0] icache_data;
  logic        lsb_req, lsb_wr;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr, lsb_wdata;
  logic        lsb_ready;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  logic [7:0]  ram [0:65535];
  logic [31:0] wlog_a[$];
  logic [7:0]  wlog_d[$];
  int          tests = 0;
  int          fails = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_ready(icache_ready), .icache_data(icache_data),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size),
    .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
    .lsb_ready(lsb_ready), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  assign mem_din = ram[mem_a[15:0]];

  always @(negedge clk) begin
    if (mem_wr) begin
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_dout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0;
    icache_req = 1'b0; icache_addr = 32'h0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_size = 2'b00; lsb_addr = 32'h0; lsb_wdata = 32'h0;
    io_buffer_full = 1'b0;
    tick(); tick();
    tests++; if (mem_a !== 32'h0)     begin fails++; $display("FAIL rst_mem_a got %h exp 0", mem_a); end
    tests++; if (mem_wr !== 1'b0)     begin fails++; $display("FAIL rst_mem_wr got %b exp 0", mem_wr); end
    tests++; if (mem_dout !== 8'h0)   begin fails++; $display("FAIL rst_mem_dout got %h exp 0", mem_dout); end
    tests++; if (icache_ready !== 1'b0 || lsb_ready !== 1'b0)
      begin fails++; $display("FAIL rst_ready got %b%b exp 00", icache_ready, lsb_ready); end
    tests++; if (icache_data !== 32'h0 || lsb_rdata !== 32'h0)
      begin fails++; $display("FAIL rst_data got %h/%h exp 0", icache_data, lsb_rdata); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    logic [31:0] exp_a;
    int n;
    icache_req = 1'b1; icache_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_a = 32'h100 + k;
      tests++; if (mem_a !== exp_a) begin fails++; $display("FAIL fetch_addr%0d got %h exp %h", k, mem_a, exp_a); end
    end
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (icache_ready) begin n = i; break; end
    end
    tests++; if (n !== 2) begin fails++; $display("FAIL fetch_latency got %0d exp 2", n); end
    tests++; if (icache_data !== 32'h00000513) begin fails++; $display("FAIL fetch_data got %h exp 00000513", icache_data); end
    icache_req = 1'b0;
    tick();
    tests++; if (icache_ready !== 1'b0) begin fails++; $display("FAIL fetch_pulse_width got %b exp 0", icache_ready); end
    tick();
  endtask

  task automatic test_priority();
    int n;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b10; lsb_addr = 32'h200;
    icache_req = 1'b1; icache_addr = 32'h100;
    tick();
    tests++; if (mem_a !== 32'h200) begin fails++; $display("FAIL prio_first got %h exp 00000200", mem_a); end
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (lsb_ready) begin n = i; break; end
    end
    tests++; if (n !== 5) begin fails++; $display("FAIL prio_lsb_latency got %0d exp 5", n); end
    tests++; if (lsb_rdata !== 32'h12345678) begin fails++; $display("FAIL prio_lsb_data got %h exp 12345678", lsb_rdata); end
    lsb_req = 1'b0;
    tick();
    tests++; if (mem_a !== 32'h0) begin fails++; $display("FAIL prio_done_gap got %h exp 0", mem_a); end
    tick();
    tests++; if (mem_a !== 32'h100) begin fails++; $display("FAIL prio_second got %h exp 00000100", mem_a); end
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (icache_ready) begin n = i; break; end
    end
    tests++; if (n !== 5 || icache_data !== 32'h00000513)
      begin fails++; $display("FAIL prio_fetch got lat %0d data %h exp 5 00000513", n, icache_data); end
    icache_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_io_stall();
    wlog_a.delete(); wlog_d.delete();
    io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b00; lsb_addr = 32'h30000; lsb_wdata = 32'h41;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL io_stall%0d got mem_wr %b exp 0", i, mem_wr); end
    end
    io_buffer_full = 1'b0;
    tick();
    tests++; if (mem_wr !== 1'b1 || mem_dout !== 8'h41 || mem_a !== 32'h30000)
      begin fails++; $display("FAIL io_beat got wr %b dout %h a %h exp 1 41 00030000", mem_wr, mem_dout, mem_a); end
    tick();
    tests++; if (mem_wr !== 1'b0 || lsb_ready !== 1'b1)
      begin fails++; $display("FAIL io_done got wr %b ready %b exp 0 1", mem_wr, lsb_ready); end
    lsb_req = 1'b0;
    tick();
    tests++; if (wlog_a.size() !== 1) begin fails++; $display("FAIL io_beat_count got %0d exp 1", wlog_a.size()); end
  endtask

  task automatic test_clear_fetch();
    int n;
    logic saw;
    saw = 1'b0;
    icache_req = 1'b1; icache_addr = 32'h100;
    tick();
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b01; lsb_addr = 32'h200;
    tick();
    saw = saw | icache_ready;
    rob_clear = 1'b1; icache_req = 1'b0;
    tick();
    saw = saw | icache_ready;
    tests++; if (mem_a !== 32'h0) begin fails++; $display("FAIL clr_abort got %h exp 0", mem_a); end
    rob_clear = 1'b0;
    tick();
    tests++; if (mem_a !== 32'h200) begin fails++; $display("FAIL clr_lsb_grant got %h exp 00000200", mem_a); end
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      saw = saw | icache_ready;
      if (lsb_ready) begin n = i; break; end
    end
    tests++; if (n !== 3 || lsb_rdata !== 32'h00005678)
      begin fails++; $display("FAIL clr_lsb_done got lat %0d data %h exp 3 00005678", n, lsb_rdata); end
    tests++; if (saw !== 1'b0) begin fails++; $display("FAIL clr_no_iready got %b exp 0", saw); end
    lsb_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_clear_store();
    int n;
    logic [31:0] ea;
    logic [7:0]  ed;
    logic [31:0] sw_data;
    sw_data = 32'hDEADBEEF;
    wlog_a.delete(); wlog_d.delete();
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b10; lsb_addr = 32'h1000; lsb_wdata = sw_data;
    tick();
    rob_clear = 1'b1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (lsb_ready) begin n = i; break; end
    end
    tests++; if (n !== 4) begin fails++; $display("FAIL st_clr_ready got %0d exp 4", n); end
    tests++; if (wlog_a.size() !== 4) begin fails++; $display("FAIL st_clr_beats got %0d exp 4", wlog_a.size()); end
    for (int k = 0; k < 4; k++) begin
      ea = 32'h1000 + k;
      ed = sw_data[8*k +: 8];
      tests++;
      if (k >= wlog_a.size()) begin
        fails++; $display("FAIL st_clr_byte%0d missing exp %h@%h", k, ed, ea);
      end else if (wlog_a[k] !== ea || wlog_d[k] !== ed) begin
        fails++; $display("FAIL st_clr_byte%0d got %h@%h exp %h@%h", k, wlog_d[k], wlog_a[k], ed, ea);
      end
    end
    rob_clear = 1'b0; lsb_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_rdy_freeze();
    int n;
    logic frozen_ok;
    frozen_ok = 1'b1;
    icache_req = 1'b1; icache_addr = 32'h100;
    tick();
    tick();
    tests++; if (mem_a !== 32'h101) begin fails++; $display("FAIL rdy_pre got %h exp 00000101", mem_a); end
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_a !== 32'h101 || icache_ready !== 1'b0) frozen_ok = 1'b0;
    end
    tests++; if (frozen_ok !== 1'b1) begin fails++; $display("FAIL rdy_frozen got %b exp 1 (a %h)", frozen_ok, mem_a); end
    rdy = 1'b1;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (icache_ready) begin n = i; break; end
    end
    tests++; if (n + 5 !== 9) begin fails++; $display("FAIL rdy_latency got %0d exp 9", n + 5); end
    tests++; if (icache_data !== 32'h00000513) begin fails++; $display("FAIL rdy_data got %h exp 00000513", icache_data); end
    icache_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_sizes_wrap();
    int n;
    ram[16'hFFFF] = 8'hAA; ram[16'h0000] = 8'h55;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b01; lsb_addr = 32'hFFFFFFFF;
    tick();
    tests++; if (mem_a !== 32'hFFFFFFFF) begin fails++; $display("FAIL wrap_a0 got %h exp ffffffff", mem_a); end
    tick();
    tests++; if (mem_a !== 32'h0) begin fails++; $display("FAIL wrap_a1 got %h exp 0", mem_a); end
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (lsb_ready) begin n = i; break; end
    end
    tests++; if (n !== 2 || lsb_rdata !== 32'h000055AA)
      begin fails++; $display("FAIL wrap_lh got lat %0d data %h exp 2 000055aa", n, lsb_rdata); end
    lsb_req = 1'b0;
    tick();
    lsb_req = 1'b1; lsb_size = 2'b00; lsb_addr = 32'h203;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (lsb_ready) begin n = i; break; end
    end
    tests++; if (n !== 3 || lsb_rdata !== 32'h00000012)
      begin fails++; $display("FAIL lb_zext got lat %0d data %h exp 3 00000012", n, lsb_rdata); end
    lsb_req = 1'b0;
    tick(); tick();
  endtask

`ifdef MEM_ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    int n;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b00; lsb_addr = 32'h200;
    icache_req = 1'b1; icache_addr = 32'h100;
    tick();
    tests++; if (mem_a !== 32'h100) begin fails++; $display("FAIL rr_first got %h exp 00000100", mem_a); end
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (icache_ready) begin n = i; break; end
    end
    icache_req = 1'b0;
    tick(); tick();
    tests++; if (mem_a !== 32'h200) begin fails++; $display("FAIL rr_second got %h exp 00000200", mem_a); end
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (lsb_ready) break;
    end
    lsb_req = 1'b0;
    tick(); tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
    ram[16'h0200] = 8'h78; ram[16'h0201] = 8'h56; ram[16'h0202] = 8'h34; ram[16'h0203] = 8'h12;
    test_reset();
    test_fetch();
    test_priority();
    test_io_stall();
    test_clear_fetch();
    test_clear_store();
    test_rdy_freeze();
    test_sizes_wrap();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    test_round_robin();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
